// File: rtl/time_bcd_cnt.sv
// BCD time-of-day counter (HH:MM:SS.mmm) with validated load and PPS re-phasing.
// Also holds the shared time_t definition that the display logic consumes.
package types_pkg;
    typedef struct packed {
        logic [3:0] t_10h;
        logic [3:0] t_1h;
        logic [3:0] t_10m;
        logic [3:0] t_1m;
        logic [3:0] t_10s;
        logic [3:0] t_1s;
        logic [3:0] t_100ms;
        logic [3:0] t_10ms;
        logic [3:0] t_1ms;
    } time_t;
endpackage

module time_bcd_cnt
    import types_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  tick_1ms,
    input  logic  pps,
    input  logic  load,
    input  time_t load_time,
    output time_t time_out,
    output logic  sec_pulse,
    output logic  day_pulse,
    output logic  load_err,
    output logic  time_valid
);

    time_t time_d, time_q;
    logic  sec_pulse_d, sec_pulse_q;
    logic  day_pulse_d, day_pulse_q;
    logic  load_err_d, load_err_q;
    logic  valid_d, valid_q;

    logic  load_ok;
    logic  at_day_end_sec;
    logic  ms_all_max;

    // Advance seconds and above by one with full carry; ms digits are left alone.
    function automatic time_t add_sec(input time_t t);
        time_t r;
        r = t;
        if (t.t_1s != 4'd9) begin
            r.t_1s = t.t_1s + 4'd1;
        end else begin
            r.t_1s = '0;
            if (t.t_10s != 4'd5) begin
                r.t_10s = t.t_10s + 4'd1;
            end else begin
                r.t_10s = '0;
                if (t.t_1m != 4'd9) begin
                    r.t_1m = t.t_1m + 4'd1;
                end else begin
                    r.t_1m = '0;
                    if (t.t_10m != 4'd5) begin
                        r.t_10m = t.t_10m + 4'd1;
                    end else begin
                        r.t_10m = '0;
                        if (t.t_10h == 4'd2 && t.t_1h == 4'd3) begin
                            r.t_10h = '0;
                            r.t_1h  = '0;
                        end else if (t.t_1h != 4'd9) begin
                            r.t_1h = t.t_1h + 4'd1;
                        end else begin
                            r.t_1h  = '0;
                            r.t_10h = t.t_10h + 4'd1;
                        end
                    end
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        load_ok = (load_time.t_1ms   <= 4'd9) && (load_time.t_10ms <= 4'd9) &&
                  (load_time.t_100ms <= 4'd9) && (load_time.t_1s   <= 4'd9) &&
                  (load_time.t_10s   <= 4'd5) && (load_time.t_1m   <= 4'd9) &&
                  (load_time.t_10m   <= 4'd5) && (load_time.t_1h   <= 4'd9) &&
                  (load_time.t_10h   <= 4'd2) &&
                  ((load_time.t_10h != 4'd2) || (load_time.t_1h <= 4'd3));

        at_day_end_sec = (time_q.t_10h == 4'd2) && (time_q.t_1h == 4'd3) &&
                         (time_q.t_10m == 4'd5) && (time_q.t_1m == 4'd9) &&
                         (time_q.t_10s == 4'd5) && (time_q.t_1s == 4'd9);

        ms_all_max = (time_q.t_100ms == 4'd9) && (time_q.t_10ms == 4'd9) &&
                     (time_q.t_1ms == 4'd9);

        time_d      = time_q;
        sec_pulse_d = 1'b0;
        day_pulse_d = 1'b0;
        load_err_d  = 1'b0;
        valid_d     = valid_q;

        if (load) begin
            if (load_ok) begin
                time_d  = load_time;
                valid_d = 1'b1;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (pps) begin
            if (time_q.t_100ms >= 4'd5) begin
                time_d      = add_sec(time_q);
                sec_pulse_d = 1'b1;
                day_pulse_d = at_day_end_sec;
            end
            time_d.t_100ms = '0;
            time_d.t_10ms  = '0;
            time_d.t_1ms   = '0;
        end else if (tick_1ms) begin
            if (ms_all_max) begin
                time_d      = add_sec(time_q);
                sec_pulse_d = 1'b1;
                day_pulse_d = at_day_end_sec;
                time_d.t_100ms = '0;
                time_d.t_10ms  = '0;
                time_d.t_1ms   = '0;
            end else if (time_q.t_1ms != 4'd9) begin
                time_d.t_1ms = time_q.t_1ms + 4'd1;
            end else begin
                time_d.t_1ms = '0;
                if (time_q.t_10ms != 4'd9) begin
                    time_d.t_10ms = time_q.t_10ms + 4'd1;
                end else begin
                    time_d.t_10ms  = '0;
                    time_d.t_100ms = time_q.t_100ms + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            time_q      <= '0;
            sec_pulse_q <= 1'b0;
            day_pulse_q <= 1'b0;
            load_err_q  <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            time_q      <= time_d;
            sec_pulse_q <= sec_pulse_d;
            day_pulse_q <= day_pulse_d;
            load_err_q  <= load_err_d;
            valid_q     <= valid_d;
        end
    end

    assign time_out   = time_q;
    assign sec_pulse  = sec_pulse_q;
    assign day_pulse  = day_pulse_q;
    assign load_err   = load_err_q;
    assign time_valid = valid_q;

endmodule
